// File: rtl/countdown_timer_12b_pkg.sv
// Shared constants and state encoding for the 12-bit loadable countdown timer.
package countdown_timer_12b_pkg;

  localparam int unsigned DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_12b_dec_sat.sv
// Saturating decrement with zero/one detect; pure combinational helper for the timer.
module countdown_timer_12b_dec_sat
  import countdown_timer_12b_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_dec,
  output logic             is_zero,
  output logic             is_one
);

  always_comb begin
    is_zero   = (value == '0);
    is_one    = (value == WIDTH'(1));
    // Saturate at zero so the counter can never wrap to all-ones.
    value_dec = is_zero ? '0 : value - WIDTH'(1);
  end

endmodule

// File: rtl/countdown_timer_12b.sv
// Loadable down-counter/timer with one-cycle done pulse and optional auto-reload.
module countdown_timer_12b
  import countdown_timer_12b_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             done,
  output logic             busy
);

  state_t           state, state_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic [WIDTH-1:0] count_next;
  logic             done_next;
  logic [WIDTH-1:0] count_dec;
  logic             cnt_zero;
  logic             cnt_one;

  countdown_timer_12b_dec_sat #(
    .WIDTH(WIDTH)
  ) u_dec (
    .value     (count),
    .value_dec (count_dec),
    .is_zero   (cnt_zero),
    .is_one    (cnt_one)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      done   <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    done_next   = 1'b0;

    if (load) begin
      count_next  = data;
      reload_next = data;
      state_next  = IDLE;
    end else if (enable) begin
      case (state)
        // IDLE and RUN share the step/expiry rules; only RUN reloads from zero.
        IDLE, RUN: begin
          if (cnt_one) begin
            count_next = '0;
            done_next  = 1'b1;
            state_next = auto_reload ? RUN : EXPIRED;
          end else if (!cnt_zero) begin
            count_next = count_dec;
            state_next = RUN;
          end else if (state == RUN) begin
            count_next = reload;
          end
        end
        EXPIRED: begin
          state_next = EXPIRED;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    zero = cnt_zero;
    busy = (state == RUN);
  end

endmodule

// File: tb/tb_countdown_timer_12b.sv
// Randomised scoreboard bench for countdown_timer_12b against a rule-level reference model.
module tb_countdown_timer_12b;

  localparam int unsigned W = 12;

  typedef struct packed {
    logic [W-1:0] count;
    logic         zero;
    logic         done;
    logic         busy;
  } obs_t;

  logic         clk;
  logic         reset;
  logic         load;
  logic         enable;
  logic         auto_reload;
  logic [W-1:0] data;
  logic [W-1:0] count;
  logic         zero;
  logic         done;
  logic         busy;

  countdown_timer_12b #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .enable      (enable),
    .auto_reload (auto_reload),
    .data        (data),
    .count       (count),
    .zero        (zero),
    .done        (done),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  obs_t  exp_q[$];
  string name_q[$];
  int    tests;
  int    fails;
  bit    stop_req;
  event  chk_ev;

  // Reference model: remaining count, preset value, and whether a countdown
  // is in progress or has finished in one-shot mode.
  int    m_cnt;
  int    m_rld;
  bit    m_running;
  bit    m_expired;
  bit    m_done;

  function automatic obs_t model_obs();
    obs_t o;
    o.count = m_cnt[W-1:0];
    o.zero  = (m_cnt == 0);
    o.done  = m_done;
    o.busy  = m_running;
    return o;
  endfunction

  task automatic model_reset();
    m_cnt     = 0;
    m_rld     = 0;
    m_running = 1'b0;
    m_expired = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic model_edge(input bit ld, input bit en, input bit ar, input int d);
    m_done = 1'b0;
    if (ld) begin
      m_cnt     = d;
      m_rld     = d;
      m_running = 1'b0;
      m_expired = 1'b0;
    end else if (en && !m_expired) begin
      if (m_cnt == 1) begin
        m_cnt  = 0;
        m_done = 1'b1;
        if (ar) begin
          m_running = 1'b1;
        end else begin
          m_running = 1'b0;
          m_expired = 1'b1;
        end
      end else if (m_cnt > 1) begin
        m_cnt     = m_cnt - 1;
        m_running = 1'b1;
      end else if (m_running) begin
        m_cnt = m_rld;
      end
    end
  endtask

  // One clock cycle of stimulus: drive at the falling edge, queue what the
  // DUT must show after the following rising edge.
  task automatic drive(input bit rst_n, input bit ld, input bit en, input bit ar,
                       input int d, input string nm);
    @(negedge clk);
    reset       = rst_n;
    load        = ld;
    enable      = en;
    auto_reload = ar;
    data        = d[W-1:0];
    if (!rst_n) model_reset();
    else        model_edge(ld, en, ar, d);
    exp_q.push_back(model_obs());
    name_q.push_back(nm);
  endtask

  // Monitor: pops one expectation per rising edge (or per async check event).
  initial begin
    obs_t  e;
    obs_t  a;
    string nm;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (stop_req) begin
        tests++;
        if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end else if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{count: count, zero: zero, done: done, busy: busy};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s @%0t: got count=%h zero=%b done=%b busy=%b, required count=%h zero=%b done=%b busy=%b",
                   nm, $time, a.count, a.zero, a.done, a.busy, e.count, e.zero, e.done, e.busy);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests       = 0;
    fails       = 0;
    stop_req    = 1'b0;
    reset       = 1'b0;
    load        = 1'b0;
    enable      = 1'b0;
    auto_reload = 1'b0;
    data        = '0;
    model_reset();

    // Reset held with a non-zero preset on the bus, then one-shot countdown from 5.
    drive(0, 0, 0, 0, 5, "reset");
    drive(0, 0, 1, 0, 5, "reset");
    drive(1, 1, 0, 0, 5, "load5");
    for (int unsigned i = 0; i < 10; i++) drive(1, 0, 1, 0, 5, "oneshot5");

    // Auto-reload period of reload+1.
    drive(1, 1, 0, 1, 3, "load3");
    for (int unsigned i = 0; i < 12; i++) drive(1, 0, 1, 1, 3, "reload3");

    // Gapped enable: only enabled cycles decrement.
    drive(1, 1, 0, 0, 'h0F7, "loadF7");
    for (int unsigned i = 0; i < 500; i++) drive(1, 0, (i % 2) == 0, 0, 'h0F7, "gapped");

    // Load wins over enable in the same cycle.
    drive(1, 1, 0, 0, 'hFFE, "loadFFE");
    for (int unsigned i = 0; i < 10; i++) drive(1, 0, 1, 0, 'hFFE, "runFFE");
    drive(1, 1, 1, 0, 2, "load_over_en");
    for (int unsigned i = 0; i < 4; i++) drive(1, 0, 1, 0, 2, "tail2");

    // Maximum reload value gives a 4096-cycle period.
    drive(1, 1, 0, 1, 'hFFF, "loadFFF");
    for (int unsigned i = 0; i < 4100; i++) drive(1, 0, 1, 1, 'hFFF, "periodFFF");

    // Asynchronous reset between clock edges while counting.
    drive(1, 1, 0, 0, 'h7F5, "load7F5");
    for (int unsigned i = 0; i < 5; i++) drive(1, 0, 1, 0, 'h7F5, "run7F0");
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    exp_q.push_back(model_obs());
    name_q.push_back("async_reset");
    ->chk_ev;
    drive(0, 0, 1, 0, 0, "reset_hold");
    drive(1, 1, 0, 0, 0, "load0");
    for (int unsigned i = 0; i < 4; i++) drive(1, 0, 1, 1, 0, "zero_no_start");

    // Random traffic.
    for (int unsigned i = 0; i < 2000; i++) begin
      bit r;
      bit l;
      int d;
      r = ($urandom_range(0, 99) != 0);
      l = ($urandom_range(0, 19) == 0);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 6));
      drive(r, l, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, d, "random");
    end

    @(posedge clk);
    #2;
    stop_req = 1'b1;
    ->chk_ev;
    #100;
    $display("FAIL monitor: did not reach summary");
    $fatal(1, "monitor stalled");
  end

endmodule
